inst_queue: RTL and testbench
=============================

Name: inst_queue

Overview:
- FIFO of fetched instructions between the fetcher/icache and the decode/issue stage.
- Buffers {instruction word, PC, predicted-taken bit} so fetch and issue run decoupled.
- Presents the head entry first-word-fall-through. The decoder reads the head instruction word directly; the issue logic pops the entry when it dispatches.
- Flushed in one cycle on a ROB misprediction clear.

Parameters:
- DEPTH, 16, number of entries; must be a power of 2, at least 2.
- ADDR_W, 4, pointer width; must equal log2(DEPTH).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- rdy  input  1  global enable; when 0, all state holds.
- clr  input  1  misprediction flush from the ROB; synchronous.
- in_valid  input  1  fetcher presents an instruction this cycle.
- in_inst  input  32  instruction word.
- in_pc  input  32  PC of in_inst.
- in_pred_jump  input  1  branch predictor's taken decision for in_inst.
- full  output  1  queue holds DEPTH entries; a push is not accepted.
- out_valid  output  1  head entry is valid (queue not empty).
- out_inst  output  32  head instruction word; feeds the decoder input_inst.
- out_pc  output  32  head PC.
- out_pred_jump  output  1  head predicted-taken bit.
- issue_en  input  1  consumer pops the head this cycle.
- count  output  ADDR_W+1  current occupancy, 0..DEPTH.

Behaviour:
- Storage: DEPTH-entry arrays inst/pc/pred. Registers: head, tail (ADDR_W bits, wrap modulo DEPTH) and cnt (ADDR_W+1 bits).
- Reset (rst=0, asynchronous): head=0, tail=0, cnt=0, so full=0, out_valid=0 and count=0. out_inst/out_pc/out_pred_jump read entry 0 and are don't-care while out_valid=0.
- Entry arrays are not required to reset. The bench must not check them while out_valid=0.
- Combinational outputs:
  - full = (cnt == DEPTH)
  - out_valid = (cnt != 0)
  - out_* = arrays[head]
  - count = cnt
- push = in_valid && !full. It is evaluated against cnt at the start of the cycle. A pop in the same cycle does not free a slot for that cycle's push.
- pop = issue_en && out_valid. issue_en while empty is ignored, with no pointer or count change.
- Per rising edge, in priority order:
  1. rdy=0: hold all state. clr and in_valid are ignored.
  2. clr=1: head=0, tail=0, cnt=0. Any same-cycle push or pop is discarded.
  3. Otherwise:
     - push: write arrays[tail], then tail=tail+1 (wraps DEPTH-1 to 0).
     - pop: head=head+1 (wraps).
     - cnt: +1 on push only, -1 on pop only, unchanged on both or neither.
- Latency:
  - A pushed entry is visible on out_* in the cycle after the push edge. There is no same-cycle bypass.
  - After a pop edge, the next entry appears immediately.
- Simultaneous push and pop with 0<cnt<DEPTH: both occur and cnt is unchanged.
- Push and pop with cnt=0: push only.
- in_valid with cnt=DEPTH: the instruction is dropped. The fetcher must hold its data and retry while full=1.
- Overflow/underflow of cnt must be impossible by construction.
- Mid-operation reset: immediate return to the reset state. Entries are lost.

Test Plan:
- Reset, then push 3 instructions (0x00000013@PC 0x0, 0x00100093@0x4, 0x00200113@0x8) with issue_en=0 -> count=3, out_valid=1, out_inst=0x00000013, out_pc=0x0.
- Push 16 entries with issue_en=0, then push a 17th (inst 0xDEADBEEF) -> full=1, count=16. Pop 16 entries -> they come out in order, 0xDEADBEEF never appears, final out_valid=0, count=0.
- Fill 10 entries, then hold in_valid=1 and issue_en=1 for 20 cycles -> count stays 10, pointers wrap past 15→0, output order matches push order.
- Fill 5 entries, assert clr together with in_valid=1 and issue_en=1 -> next cycle count=0, out_valid=0. A following push of 0x0000006F@0x100 appears as the head with out_pred_jump as driven.
- With 4 entries, rdy=0 for 3 cycles while in_valid=1, issue_en=1, clr=1 -> count stays 4, head unchanged. Restore rdy=1 -> normal operation resumes.
- Drive rst=0 asynchronously between edges with 7 entries -> full=0, out_valid=0 and count=0 without waiting for a clock edge.

Source files
------------

// File: rtl/inst_queue_if.sv
// inst_queue_if: fetch-side push and issue-side pop/head signals of the instruction queue
interface inst_queue_if #(parameter int ADDR_W = 4);
  logic              in_valid;
  logic [31:0]       in_inst;
  logic [31:0]       in_pc;
  logic              in_pred_jump;
  logic              full;
  logic              out_valid;
  logic [31:0]       out_inst;
  logic [31:0]       out_pc;
  logic              out_pred_jump;
  logic              issue_en;
  logic [ADDR_W:0]   count;
  modport master (
    output in_valid, in_inst, in_pc, in_pred_jump, issue_en,
    input  full, out_valid, out_inst, out_pc, out_pred_jump, count
  );
  modport slave (
    input  in_valid, in_inst, in_pc, in_pred_jump, issue_en,
    output full, out_valid, out_inst, out_pc, out_pred_jump, count
  );
endinterface

// File: rtl/inst_queue.sv
// inst_queue: first-word-fall-through FIFO of {inst, pc, pred} between fetch and issue
module inst_queue #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic rdy,
  input  logic clr,
  inst_queue_if.slave q
);
  logic [31:0]     inst_mem [DEPTH];
  logic [31:0]     pc_mem   [DEPTH];
  logic            pred_mem [DEPTH];
  logic [ADDR_W-1:0] head, tail;
  logic [ADDR_W:0]   cnt;
  logic push, pop;
  assign q.full          = cnt == (ADDR_W+1)'(DEPTH);
  assign q.out_valid     = cnt != '0;
  assign q.out_inst      = inst_mem[head];
  assign q.out_pc        = pc_mem[head];
  assign q.out_pred_jump = pred_mem[head];
  assign q.count         = cnt;
  assign push = q.in_valid && !q.full;
  assign pop  = q.issue_en && q.out_valid;
  // pointers and occupancy: hold on !rdy, flush on clr, else advance on push/pop
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else if (rdy) begin
      if (clr) begin
        head <= '0;
        tail <= '0;
        cnt  <= '0;
      end else begin
        if (push) tail <= tail + ADDR_W'(1);
        if (pop) head <= head + ADDR_W'(1);
        cnt <= cnt + (ADDR_W+1)'(push) - (ADDR_W+1)'(pop);
      end
    end
  end
  // entry storage is unreset; a slot is only read once cnt says it was written
  always_ff @(posedge clk) begin
    if (rdy && !clr && push) begin
      inst_mem[tail] <= q.in_inst;
      pc_mem[tail]   <= q.in_pc;
      pred_mem[tail] <= q.in_pred_jump;
    end
  end
endmodule

// File: tb/tb_inst_queue.sv
// tb_inst_queue: vector table plus directed sequences for full, wrap and async reset
module tb_inst_queue;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rdy = 1'b1;
  logic clr = 1'b0;
  int n_cmp = 0;
  int n_bad = 0;
  inst_queue_if #(.ADDR_W(4)) q ();
  inst_queue #(.DEPTH(16), .ADDR_W(4)) dut (.clk(clk), .rst(rst), .rdy(rdy), .clr(clr), .q(q));
  always #5 clk = ~clk;
  typedef struct {
    logic rdy, clr, iv;
    logic [31:0] inst, pc;
    logic pj, ie;
    logic [4:0] cnt;
    logic vld, full, chk;
    logic [31:0] einst, epc;
    logic epj;
  } vec_t;
  vec_t vecs[12];
  logic [31:0] exp_q[$];
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic drive(input logic r, input logic c, input logic iv, input logic [31:0] inst,
                       input logic [31:0] pc, input logic pj, input logic ie);
    rdy = r;
    clr = c;
    q.in_valid = iv;
    q.in_inst = inst;
    q.in_pc = pc;
    q.in_pred_jump = pj;
    q.issue_en = ie;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle_tick();
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    tick();
  endtask
  initial begin
    vecs[0]  = '{1'b1,1'b0,1'b1,32'h00000013,32'h0,1'b0,1'b0, 5'd1,1'b1,1'b0,1'b1,32'h00000013,32'h0,1'b0};
    vecs[1]  = '{1'b1,1'b0,1'b1,32'h00100093,32'h4,1'b1,1'b0, 5'd2,1'b1,1'b0,1'b1,32'h00000013,32'h0,1'b0};
    vecs[2]  = '{1'b1,1'b0,1'b1,32'h00200113,32'h8,1'b0,1'b0, 5'd3,1'b1,1'b0,1'b1,32'h00000013,32'h0,1'b0};
    vecs[3]  = '{1'b1,1'b0,1'b0,32'h0,32'h0,1'b0,1'b1, 5'd2,1'b1,1'b0,1'b1,32'h00100093,32'h4,1'b1};
    vecs[4]  = '{1'b1,1'b0,1'b1,32'h00300193,32'hC,1'b1,1'b1, 5'd2,1'b1,1'b0,1'b1,32'h00200113,32'h8,1'b0};
    vecs[5]  = '{1'b0,1'b1,1'b1,32'h0BAD0BAD,32'h0,1'b0,1'b1, 5'd2,1'b1,1'b0,1'b1,32'h00200113,32'h8,1'b0};
    vecs[6]  = '{1'b0,1'b1,1'b1,32'h0BAD0BAD,32'h0,1'b0,1'b1, 5'd2,1'b1,1'b0,1'b1,32'h00200113,32'h8,1'b0};
    vecs[7]  = '{1'b1,1'b0,1'b0,32'h0,32'h0,1'b0,1'b1, 5'd1,1'b1,1'b0,1'b1,32'h00300193,32'hC,1'b1};
    vecs[8]  = '{1'b1,1'b1,1'b1,32'h0BAD0BAD,32'h0,1'b0,1'b1, 5'd0,1'b0,1'b0,1'b0,32'h0,32'h0,1'b0};
    vecs[9]  = '{1'b1,1'b0,1'b0,32'h0,32'h0,1'b0,1'b1, 5'd0,1'b0,1'b0,1'b0,32'h0,32'h0,1'b0};
    vecs[10] = '{1'b1,1'b0,1'b1,32'h0000006F,32'h100,1'b1,1'b1, 5'd1,1'b1,1'b0,1'b1,32'h0000006F,32'h100,1'b1};
    vecs[11] = '{1'b1,1'b0,1'b0,32'h0,32'h0,1'b0,1'b1, 5'd0,1'b0,1'b0,1'b0,32'h0,32'h0,1'b0};
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    #2;
    check("reset_count", 32'(q.count), 32'd0);
    check("reset_valid", 32'(q.out_valid), 32'd0);
    check("reset_full", 32'(q.full), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].rdy, vecs[i].clr, vecs[i].iv, vecs[i].inst, vecs[i].pc, vecs[i].pj, vecs[i].ie);
      tick();
      check($sformatf("v%0d_count", i), 32'(q.count), 32'(vecs[i].cnt));
      check($sformatf("v%0d_valid", i), 32'(q.out_valid), 32'(vecs[i].vld));
      check($sformatf("v%0d_full", i), 32'(q.full), 32'(vecs[i].full));
      if (vecs[i].chk) begin
        check($sformatf("v%0d_inst", i), q.out_inst, vecs[i].einst);
        check($sformatf("v%0d_pc", i), q.out_pc, vecs[i].epc);
        check($sformatf("v%0d_pred", i), 32'(q.out_pred_jump), 32'(vecs[i].epj));
      end
    end
    // fill to full, overflow attempt, then drain in order
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 1'b0, 1'b1, 32'h1000 + 32'(i), 32'(4 * i), 1'((i & 1)), 1'b0);
      tick();
    end
    check("fill_count", 32'(q.count), 32'd16);
    check("fill_full", 32'(q.full), 32'd1);
    drive(1'b1, 1'b0, 1'b1, 32'hDEADBEEF, 32'hFFFC, 1'b1, 1'b0);
    tick();
    check("ovf_count", 32'(q.count), 32'd16);
    check("ovf_full", 32'(q.full), 32'd1);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("drain%0d_inst", i), q.out_inst, 32'h1000 + 32'(i));
      check($sformatf("drain%0d_pc", i), q.out_pc, 32'(4 * i));
      check($sformatf("drain%0d_pred", i), 32'(q.out_pred_jump), 32'(i & 1));
      drive(1'b1, 1'b0, i == 0, 32'hDEADBEEF, 32'hFFFC, 1'b1, 1'b1);
      tick();
      check($sformatf("drain%0d_count", i), 32'(q.count), 32'(15 - i));
    end
    check("drain_valid", 32'(q.out_valid), 32'd0);
    check("drain_full", 32'(q.full), 32'd0);
    // steady push+pop at 10 entries wraps both pointers
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'b0, 1'b1, 32'h2000 + 32'(i), 32'h8000 + 32'(i), 1'b0, 1'b0);
      exp_q.push_back(32'h2000 + 32'(i));
      tick();
    end
    check("wrap_fill_count", 32'(q.count), 32'd10);
    for (int k = 0; k < 20; k++) begin
      check($sformatf("wrap%0d_inst", k), q.out_inst, exp_q[0]);
      check($sformatf("wrap%0d_pc", k), q.out_pc, exp_q[0] + 32'h6000);
      drive(1'b1, 1'b0, 1'b1, 32'h200A + 32'(k), 32'h800A + 32'(k), 1'b0, 1'b1);
      tick();
      void'(exp_q.pop_front());
      exp_q.push_back(32'h200A + 32'(k));
      check($sformatf("wrap%0d_count", k), 32'(q.count), 32'd10);
    end
    while (exp_q.size() > 0) begin
      check("wrap_drain_inst", q.out_inst, exp_q[0]);
      drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
      tick();
      void'(exp_q.pop_front());
    end
    check("wrap_empty_valid", 32'(q.out_valid), 32'd0);
    // rdy=0 holds a 4-entry queue against clr, push and pop
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 1'b1, 32'h3000 + 32'(i), 32'h0, 1'b0, 1'b0);
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 1'b1, 32'h0BAD0BAD, 32'h0, 1'b0, 1'b1);
      tick();
      check($sformatf("hold%0d_count", i), 32'(q.count), 32'd4);
      check($sformatf("hold%0d_inst", i), q.out_inst, 32'h3000);
    end
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    tick();
    check("resume_count", 32'(q.count), 32'd3);
    check("resume_inst", q.out_inst, 32'h3001);
    // asynchronous reset between edges with 7 entries
    drive(1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    tick();
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, 1'b0, 1'b1, 32'h4000 + 32'(i), 32'h0, 1'b0, 1'b0);
      tick();
    end
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    check("pre_arst_count", 32'(q.count), 32'd7);
    #2;
    rst = 1'b0;
    #1;
    check("arst_count", 32'(q.count), 32'd0);
    check("arst_valid", 32'(q.out_valid), 32'd0);
    check("arst_full", 32'(q.full), 32'd0);
    #1;
    rst = 1'b1;
    drive(1'b1, 1'b0, 1'b1, 32'h5555AAAA, 32'h44, 1'b1, 1'b0);
    tick();
    check("post_arst_count", 32'(q.count), 32'd1);
    check("post_arst_inst", q.out_inst, 32'h5555AAAA);
    idle_tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
